// File: rtl/cache_controller_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// address geometry, field slice positions, FSM encoding and counter helper.
package cache_controller_pkg;

    localparam int TAG_W   = 7;
    localparam int IDX_W   = 6;
    localparam int OFF_W   = 3;
    localparam int ADDR_W  = TAG_W + IDX_W + OFF_W;
    localparam int BLOCK_W = 8 << OFF_W;
    localparam int CNT_W   = 16;

    // Address layout is {tag, index, offset}, offset in the low bits.
    localparam int OFF_LSB = 0;
    localparam int IDX_LSB = OFF_W;
    localparam int TAG_LSB = OFF_W + IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_WRITE_MEM = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Bundle of processor, memory and data-array signals around the controller.
// Handshake: cpu_req is taken only in IDLE, cpu_ready pulses one cycle on completion;
// mem_rd_req/mem_wr_req stay high until a one-cycle mem_ack, which is ignored otherwise.
interface cache_controller_if;
    import cache_controller_pkg::*;

    logic               cpu_req;
    logic               cpu_wr;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [7:0]         cpu_wdata;
    logic [7:0]         cpu_rdata;
    logic               cpu_ready;

    logic               mem_rd_req;
    logic               mem_wr_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [7:0]         mem_wdata;
    logic [BLOCK_W-1:0] mem_rdata;
    logic               mem_ack;

    logic [IDX_W-1:0]   da_index;
    logic [OFF_W-1:0]   da_offset;
    logic [7:0]         da_wdata;
    logic               da_wr_en;
    logic               da_update;
    logic [BLOCK_W-1:0] da_block;
    logic [7:0]         da_rdata;

    modport master (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ack, da_rdata,
        output cpu_rdata, cpu_ready, mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
        output da_index, da_offset, da_wdata, da_wr_en, da_update, da_block
    );

    modport slave (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ack, da_rdata,
        input  cpu_rdata, cpu_ready, mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
        input  da_index, da_offset, da_wdata, da_wr_en, da_update, da_block
    );

endinterface

// File: rtl/cache_controller_tag_array.sv
// Per-line {valid, tag} store: synchronous write, combinational read.
// Only the valid bits are cleared by reset; stale tags are harmless once invalid.
module cache_controller_tag_array #(
    parameter int TAG_W = 7,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_index,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [TAG_W-1:0] wr_tag
);
    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with an
// external data array; read misses fetch and install the whole line.
module cache_controller #(
    parameter int TAG_W = cache_controller_pkg::TAG_W,
    parameter int IDX_W = cache_controller_pkg::IDX_W,
    parameter int OFF_W = cache_controller_pkg::OFF_W
) (
    input  logic                        clk,
    input  logic                        rst,
    cache_controller_if.master          bus,
    output logic [15:0]                 hit_cnt,
    output logic [15:0]                 miss_cnt,
    output cache_controller_pkg::state_t dbg_state
);
    import cache_controller_pkg::*;

    localparam int A_W    = TAG_W + IDX_W + OFF_W;
    localparam int IDX_LO = OFF_W;
    localparam int TAG_LO = OFF_W + IDX_W;

    state_t           state_q;
    logic [A_W-1:0]   addr_q;
    logic             wr_q;
    logic [7:0]       wdata_q;
    logic             recmp_q;
    logic [15:0]      hit_q;
    logic [15:0]      miss_q;
    logic             mem_rd_q;
    logic             mem_wr_q;
    logic [A_W-1:0]   mem_addr_q;
    logic [7:0]       mem_wdata_q;

    logic [OFF_W-1:0] l_off;
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic             in_compare;
    logic             hit;
    logic             alloc_ack;
    logic             wmem_ack;

    assign l_off = addr_q[OFF_W-1:0];
    assign l_idx = addr_q[IDX_LO +: IDX_W];
    assign l_tag = addr_q[TAG_LO +: TAG_W];

    cache_controller_tag_array #(.TAG_W(TAG_W), .IDX_W(IDX_W)) u_tag_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (l_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .wr_en    (alloc_ack),
        .wr_index (l_idx),
        .wr_tag   (l_tag)
    );

    // Pulses tied to the hit decision or to mem_ack must appear in the same
    // cycle, so they are decoded from the registered state rather than stored.
    assign in_compare = (state_q == ST_COMPARE) && !rst;
    assign hit        = in_compare && line_valid && (line_tag == l_tag);
    assign alloc_ack  = (state_q == ST_ALLOCATE) && bus.mem_ack && !rst;
    assign wmem_ack   = (state_q == ST_WRITE_MEM) && bus.mem_ack && !rst;

    assign bus.cpu_ready  = (hit && !wr_q) || wmem_ack;
    assign bus.cpu_rdata  = bus.da_rdata;
    assign bus.da_wr_en   = hit && wr_q;
    assign bus.da_update  = alloc_ack;
    assign bus.da_wdata   = wdata_q;
    assign bus.da_block   = bus.mem_rdata;
    assign bus.da_index   = (state_q == ST_IDLE) ? bus.cpu_addr[IDX_LO +: IDX_W] : l_idx;
    assign bus.da_offset  = (state_q == ST_IDLE) ? bus.cpu_addr[OFF_W-1:0] : l_off;
    assign bus.mem_rd_req = mem_rd_q;
    assign bus.mem_wr_req = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    assign hit_cnt   = hit_q;
    assign miss_cnt  = miss_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            recmp_q     <= 1'b0;
            hit_q       <= '0;
            miss_q      <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cpu_req) begin
                        addr_q  <= bus.cpu_addr;
                        wr_q    <= bus.cpu_wr;
                        wdata_q <= bus.cpu_wdata;
                        state_q <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    // The re-compare after a line fill is bookkeeping, not a new access.
                    recmp_q <= 1'b0;
                    if (!recmp_q) begin
                        if (hit) hit_q  <= sat_inc(hit_q);
                        else     miss_q <= sat_inc(miss_q);
                    end
                    if (wr_q) begin
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= wdata_q;
                        state_q     <= ST_WRITE_MEM;
                    end else if (hit) begin
                        state_q <= ST_IDLE;
                    end else begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= {l_tag, l_idx, {OFF_W{1'b0}}};
                        state_q    <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (bus.mem_ack) begin
                        mem_rd_q <= 1'b0;
                        recmp_q  <= 1'b1;
                        state_q  <= ST_COMPARE;
                    end
                end
                ST_WRITE_MEM: begin
                    if (bus.mem_ack) begin
                        mem_wr_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a vector table of accesses with
// hand-computed results, plus saturation and reset-during-fill sequences.
module tb_cache_controller;
    import cache_controller_pkg::*;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [63:0] block;
        logic        exp_hit;
        logic [7:0]  exp_rdata;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_hits = '0;
    logic [15:0] exp_misses = '0;

    logic [63:0] darr [64];
    vec_t vecs [11];

    cache_controller_if bus ();

    cache_controller dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // external data array model
    assign bus.da_rdata = darr[bus.da_index][{bus.da_offset, 3'b000} +: 8];

    always @(posedge clk) begin
        if (bus.da_update) darr[bus.da_index] <= bus.da_block;
        else if (bus.da_wr_en) darr[bus.da_index][{bus.da_offset, 3'b000} +: 8] <= bus.da_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One processor access; acks memory on the second cycle a request is seen.
    task automatic do_access(input vec_t v, input string name);
        int cyc = 0;
        int ready_cyc = -1;
        int req_cyc = 0;
        int n_wr = 0;
        int n_upd = 0;
        logic excl_bad = 1'b0;
        logic saw_rd = 1'b0;
        logic saw_wr = 1'b0;
        logic [15:0] rd_addr = '0;
        logic [15:0] wr_addr = '0;
        logic [7:0]  wr_data = '0;
        logic [7:0]  rdata = '0;
        int exp_cyc;

        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_wr    = v.wr;
        bus.cpu_addr  = v.addr;
        bus.cpu_wdata = v.wdata;
        @(negedge clk);
        bus.cpu_req   = 1'b0;
        bus.cpu_wr    = ~v.wr;
        bus.cpu_addr  = 16'hFFFF;
        bus.cpu_wdata = 8'h5A;
        while (ready_cyc < 0 && cyc < 20) begin
            bus.mem_ack = 1'b0;
            if (bus.mem_rd_req || bus.mem_wr_req) begin
                req_cyc++;
                if (bus.mem_rd_req) begin saw_rd = 1'b1; rd_addr = bus.mem_addr; end
                if (bus.mem_wr_req) begin saw_wr = 1'b1; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata; end
                if (req_cyc == 2) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = v.block;
                end
            end
            #1;
            if (bus.da_wr_en) n_wr++;
            if (bus.da_update) n_upd++;
            if ((bus.da_wr_en && bus.da_update) || (bus.mem_rd_req && bus.mem_wr_req)) excl_bad = 1'b1;
            if (bus.cpu_ready) begin
                ready_cyc = cyc;
                rdata = bus.cpu_rdata;
            end
            @(negedge clk);
            cyc++;
        end
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        if (v.exp_hit) begin
            if (exp_hits != 16'hFFFF) exp_hits++;
        end else begin
            if (exp_misses != 16'hFFFF) exp_misses++;
        end
        exp_cyc = v.wr ? 2 : (v.exp_hit ? 0 : 3);

        check({name, ".ready_cyc"}, 64'(ready_cyc), 64'(exp_cyc));
        if (!v.wr) check({name, ".rdata"}, 64'(rdata), 64'(v.exp_rdata));
        check({name, ".mem_rd_seen"}, 64'(saw_rd), 64'(!v.wr && !v.exp_hit));
        if (saw_rd) check({name, ".mem_rd_addr"}, 64'(rd_addr), 64'({v.addr[15:3], 3'b000}));
        check({name, ".mem_wr_seen"}, 64'(saw_wr), 64'(v.wr));
        if (saw_wr) begin
            check({name, ".mem_wr_addr"}, 64'(wr_addr), 64'(v.addr));
            check({name, ".mem_wr_data"}, 64'(wr_data), 64'(v.wdata));
        end
        check({name, ".da_wr_en_cycles"}, 64'(n_wr), 64'(v.wr && v.exp_hit));
        check({name, ".da_update_cycles"}, 64'(n_upd), 64'(!v.wr && !v.exp_hit));
        check({name, ".exclusive"}, 64'(excl_bad), 64'(0));
        check({name, ".hit_cnt"}, 64'(hit_cnt), 64'(exp_hits));
        check({name, ".miss_cnt"}, 64'(miss_cnt), 64'(exp_misses));
        check({name, ".state_idle"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 16'h1234, 8'h00, 64'h0706050403020100, 1'b0, 8'h04};
        vecs[1]  = '{1'b0, 16'h1235, 8'h00, 64'h0,                1'b1, 8'h05};
        vecs[2]  = '{1'b1, 16'h1236, 8'hAA, 64'h0,                1'b1, 8'h00};
        vecs[3]  = '{1'b0, 16'h1236, 8'h00, 64'h0,                1'b1, 8'hAA};
        vecs[4]  = '{1'b1, 16'h5236, 8'h55, 64'h0,                1'b0, 8'h00};
        vecs[5]  = '{1'b0, 16'h1236, 8'h00, 64'h0,                1'b1, 8'hAA};
        vecs[6]  = '{1'b0, 16'h0008, 8'h00, 64'hF0E0D0C0B0A09080, 1'b0, 8'h80};
        vecs[7]  = '{1'b0, 16'h000F, 8'h00, 64'h0,                1'b1, 8'hF0};
        vecs[8]  = '{1'b0, 16'h5237, 8'h00, 64'h8877665544332211, 1'b0, 8'h88};
        vecs[9]  = '{1'b0, 16'h1234, 8'h00, 64'h07AA050403020100, 1'b0, 8'h04};
        vecs[10] = '{1'b0, 16'h1236, 8'h00, 64'h0,                1'b1, 8'hAA};

        for (int i = 0; i < 64; i++) darr[i] = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.cpu_ready", 64'(bus.cpu_ready), 64'(0));
        check("rst.mem_rd_req", 64'(bus.mem_rd_req), 64'(0));
        check("rst.mem_wr_req", 64'(bus.mem_wr_req), 64'(0));
        check("rst.da_wr_en", 64'(bus.da_wr_en), 64'(0));
        check("rst.da_update", 64'(bus.da_update), 64'(0));
        check("rst.mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst.mem_wdata", 64'(bus.mem_wdata), 64'(0));
        check("rst.hit_cnt", 64'(hit_cnt), 64'(0));
        check("rst.miss_cnt", 64'(miss_cnt), 64'(0));
        check("rst.state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;

        for (int i = 0; i < 11; i++) do_access(vecs[i], $sformatf("v%0d", i));

        // hit counter saturation
        force dut.hit_q = 16'hFFFE;
        @(negedge clk);
        release dut.hit_q;
        exp_hits = 16'hFFFE;
        check("sat.preset", 64'(hit_cnt), 64'(16'hFFFE));
        do_access('{1'b0, 16'h1236, 8'h00, 64'h0, 1'b1, 8'hAA}, "sat0");
        do_access('{1'b0, 16'h1235, 8'h00, 64'h0, 1'b1, 8'h05}, "sat1");
        do_access('{1'b0, 16'h1234, 8'h00, 64'h0, 1'b1, 8'h04}, "sat2");

        // reset while a line fill is outstanding, then a late ack
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 16'h2000;
        @(negedge clk);
        bus.cpu_req  = 1'b0;
        @(negedge clk);
        check("rstfill.mem_rd_req", 64'(bus.mem_rd_req), 64'(1));
        check("rstfill.mem_addr", 64'(bus.mem_addr), 64'(16'h2000));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'hDEADBEEFCAFEF00D;
        #1;
        check("rstfill.late_update", 64'(bus.da_update), 64'(0));
        check("rstfill.late_ready", 64'(bus.cpu_ready), 64'(0));
        check("rstfill.mem_rd_clear", 64'(bus.mem_rd_req), 64'(0));
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        check("rstfill.state", 64'(dbg_state), 64'(ST_IDLE));
        check("rstfill.hit_cnt", 64'(hit_cnt), 64'(0));
        check("rstfill.miss_cnt", 64'(miss_cnt), 64'(0));
        check("rstfill.line0", darr[0], 64'h0);
        exp_hits   = '0;
        exp_misses = '0;
        do_access('{1'b0, 16'h1234, 8'h00, 64'h0706050403020100, 1'b0, 8'h04}, "reread");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameters: TAG_W, 7, tag width; IDX_W, 6, index width (64 lines); OFF_W, 3, byte offset width (8 bytes/line).
REQ-002 SHALL have one clock and one reset: synchronous, active-high. Ports: clk input 1 clock; rst input 1 sync active-high reset.
REQ-003 Processor ports: cpu_req input 1 request; cpu_wr input 1 1=write; cpu_addr input 16 byte address {tag,index,offset}; cpu_wdata input 8 write byte; cpu_rdata output 8 read byte; cpu_ready output 1 one-cycle completion pulse.
REQ-004 Memory ports: mem_rd_req output 1 block read request; mem_wr_req output 1 byte write request; mem_addr output 16 address (block-aligned for reads, offset=0); mem_wdata output 8 write byte; mem_rdata input 64 fetched block; mem_ack input 1 one-cycle completion.
REQ-005 Data-array ports: da_index output 6; da_offset output 3; da_wdata output 8; da_wr_en output 1; da_update output 1; da_block output 64; da_rdata input 8 (combinational read of da_index/da_offset).
REQ-006 Statistics ports: hit_cnt output 16; miss_cnt output 16.

Function
REQ-007 Direct-mapped, write-through, no-write-allocate; read miss allocates full line.
REQ-008 States: IDLE, COMPARE, ALLOCATE, WRITE_MEM.
REQ-009 IDLE: cpu_req=1 latches cpu_addr/cpu_wr/cpu_wdata, -> COMPARE; cpu_* ignored in every other state.
REQ-010 da_index/da_offset driven from latched address in all states except IDLE; da_wdata=latched byte; da_block=mem_rdata.
REQ-011 Hit = valid[index] && tag[index]==latched tag, evaluated in COMPARE.
REQ-012 COMPARE read hit: cpu_ready=1, cpu_rdata=da_rdata same cycle, -> IDLE; hit latency 2 cycles from request edge.
REQ-013 COMPARE read miss: -> ALLOCATE; mem_rd_req=1, mem_addr={tag,index,3'b0} held until mem_ack.
REQ-014 ALLOCATE on mem_ack: da_update=1 that cycle, tag[index]<=latched tag, valid[index]<=1, -> COMPARE (guaranteed hit, completes as REQ-012).
REQ-015 COMPARE write hit: da_wr_en=1 for exactly one cycle, -> WRITE_MEM. Write miss: array untouched, -> WRITE_MEM.
REQ-016 WRITE_MEM: mem_wr_req=1, mem_addr=full latched address, mem_wdata=latched byte until mem_ack; on mem_ack cpu_ready=1, -> IDLE.
REQ-017 da_wr_en and da_update SHALL never be 1 in the same cycle; mem_rd_req and mem_wr_req mutually exclusive.
REQ-018 mem_ack outside ALLOCATE/WRITE_MEM SHALL be ignored.
REQ-019 hit_cnt increments on first COMPARE evaluation that hits; miss_cnt on each miss (read or write); the post-allocate re-compare SHALL NOT count; both saturate at 16'hFFFF.
REQ-020 cpu_rdata valid only while cpu_ready=1 on a read; otherwise don't-care but driven from da_rdata.

Reset
REQ-021 rst=1 at clk edge: state=IDLE, all 64 valid bits=0, hit_cnt=miss_cnt=0; tags not reset.
REQ-022 Reset outputs: cpu_ready=0, mem_rd_req=0, mem_wr_req=0, da_wr_en=0, da_update=0, mem_addr=0, mem_wdata=0.
REQ-023 Reset mid-ALLOCATE/WRITE_MEM SHALL abandon the transaction; late mem_ack after reset ignored; no array update.

Structure
REQ-024 Shared package SHALL hold state encoding, TAG_W/IDX_W/OFF_W, and address-field slice constants.
REQ-025 One sub-module tag_array (64 x {valid,tag}, sync write, comb read, valid clear on rst); data array instantiated externally.

Verification
REQ-026 After reset, read 0x1234 -> miss_cnt=1, mem_rd_req with mem_addr=0x1230; ack with block 0x0706050403020100 -> cpu_ready, cpu_rdata=0x04.
REQ-027 Repeat read 0x1235 -> cpu_ready 2 cycles after request, cpu_rdata=0x05, hit_cnt=1, no mem request.
REQ-028 Write 0xAA to 0x1236 (hit) -> one-cycle da_wr_en, mem_wr_req addr 0x1236 data 0xAA; after ack read 0x1236 returns 0xAA.
REQ-029 Write to 0x5236 (same index, different tag) -> no da_wr_en, mem write issued, miss_cnt increments; read 0x1236 still hits.
REQ-030 Read 0x2000 then rst during ALLOCATE, mem_ack one cycle later -> no da_update, state IDLE, re-read 0x1234 misses.
REQ-031 Force hit_cnt to 0xFFFF via repeated hits -> remains 0xFFFF on further hits.
